tx_block_scheduler: RTL and testbench

- Gen3 128b/130b block sequencer in front of the Tx scrambler-control path.
- Arbitrates each 16-symbol block among three sources: pending SKP ordered set, LTSSM ordered-set source, and the data source.
- Drives the per-beat symbol word plus the sync header that the scrambler controller decodes.
- In Gen1/2 it is a per-beat arbiter and raises turnOff while ordered sets are on the bus, so TS1/TS2 are not scrambled.

---
 rtl/tx_block_scheduler_pkg.sv | 40 ++++
 rtl/tx_block_scheduler_skp_gen.sv | 25 ++
 rtl/tx_block_scheduler.sv | 172 +++++++++++++++++
 tb/tb_tx_block_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_block_scheduler_pkg.sv
// Shared symbol constants, sync-header codes, state encoding and beat helpers
// for the Gen3 Tx block scheduler.
package tx_block_scheduler_pkg;

    localparam logic [7:0] SKPGEN3 = 8'hAA;
    localparam logic [7:0] SKP_END = 8'hE1;
    localparam logic [7:0] TS1     = 8'h1E;
    localparam logic [7:0] TS2     = 8'h2D;
    localparam logic [7:0] EIEOS   = 8'h00;
    localparam logic [7:0] COM     = 8'd188;
    localparam logic [7:0] SKP     = 8'd28;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_OS   = 2'b10;
    localparam logic [1:0] SH_NONE = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_G12      = 3'd1,
        ST_BLK_DATA = 3'd2,
        ST_BLK_OS   = 3'd3,
        ST_BLK_SKP  = 3'd4
    } state_e;

    // Unsupported widths fall back to 32 bits per beat.
    function automatic logic [4:0] bpb_from_width(input logic [5:0] pw);
        case (pw)
            6'd8:    return 5'd16;
            6'd16:   return 5'd8;
            default: return 5'd4;
        endcase
    endfunction

    function automatic logic [7:0] skp_symbol(input logic [5:0] idx);
        if (idx < 6'd12)       return SKPGEN3;
        else if (idx == 6'd12) return SKP_END;
        else                   return 8'h00;
    endfunction

endpackage

// File: rtl/tx_block_scheduler_skp_gen.sv
// Combinational SKP ordered-set word for one beat, lowest symbol in the low byte.
module tx_skp_block_gen
    import tx_block_scheduler_pkg::*;
(
    input  logic [3:0]  beat_cnt_i,
    input  logic [5:0]  pipewidth_i,
    output logic [31:0] word_o
);

    logic [2:0] spb;
    logic [5:0] base;

    always_comb begin
        case (pipewidth_i)
            6'd8:    begin spb = 3'd1; base = {2'b00, beat_cnt_i};       end
            6'd16:   begin spb = 3'd2; base = {1'b0, beat_cnt_i, 1'b0};  end
            default: begin spb = 3'd4; base = {beat_cnt_i, 2'b00};       end
        endcase
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign word_o[8*k +: 8] = (3'(k) < spb) ? skp_symbol(base + 6'(k)) : 8'h00;
    end

endmodule

// File: rtl/tx_block_scheduler.sv
// 128b/130b block sequencer (SKP / ordered set / data) with a Gen1/2 per-beat
// arbiter fallback; every output is registered.
module tx_block_scheduler
    import tx_block_scheduler_pkg::*;
#(
    parameter int SKP_INTERVAL = 370,
    parameter int CNT_W        = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  PIPEWIDTH,
    input  logic [2:0]  GEN,
    input  logic        link_up,
    input  logic        data_valid,
    input  logic [31:0] data_in,
    output logic        data_ready,
    input  logic        os_valid,
    input  logic [31:0] os_data,
    output logic        os_ready,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    output logic [1:0]  syncHeader,
    output logic        block_start,
    output logic        turnOff,
    output logic        skp_sent
);

    state_e           state_q, state_d, blk_state;
    logic [3:0]       beat_cnt_q, beat_cnt_d;
    logic [4:0]       bpb_q, bpb_d, bpb_cur;
    logic [5:0]       pw_q, pw_d, pw_cur;
    logic [CNT_W-1:0] skp_cnt_q, skp_cnt_d;
    logic             skp_pending_q, skp_pending_d;
    logic             at_bound, last_beat;
    logic [31:0]      skp_word;

    logic [31:0] tx_data_q, tx_data_d;
    logic [1:0]  sh_q, sh_d;
    logic        tx_valid_q, tx_valid_d, bs_q, bs_d, off_q, off_d;
    logic        skp_sent_q, skp_sent_d, dr_q, dr_d, or_q, or_d;

    // IDLE and G12 park beat_cnt at 0, so every cycle there is a boundary.
    assign at_bound  = (beat_cnt_q == 4'd0);
    assign pw_cur    = at_bound ? PIPEWIDTH : pw_q;
    assign bpb_cur   = at_bound ? bpb_from_width(PIPEWIDTH) : bpb_q;
    assign last_beat = ({1'b0, beat_cnt_q} == (bpb_cur - 5'd1));

    tx_skp_block_gen u_skp_gen (
        .beat_cnt_i  (beat_cnt_q),
        .pipewidth_i (pw_cur),
        .word_o      (skp_word)
    );

    always_comb begin
        blk_state = state_q;
        if (at_bound) begin
            if (!link_up)           blk_state = ST_IDLE;
            else if (GEN < 3'd3)    blk_state = ST_G12;
            else if (skp_pending_q) blk_state = ST_BLK_SKP;
            else if (os_valid)      blk_state = ST_BLK_OS;
            else                    blk_state = ST_BLK_DATA;
        end
    end

    always_comb begin
        state_d       = blk_state;
        beat_cnt_d    = 4'd0;
        bpb_d         = bpb_cur;
        pw_d          = pw_cur;
        skp_cnt_d     = skp_cnt_q;
        skp_pending_d = skp_pending_q;
        tx_data_d     = '0;
        tx_valid_d    = 1'b0;
        sh_d          = SH_NONE;
        bs_d          = 1'b0;
        off_d         = 1'b0;
        skp_sent_d    = 1'b0;
        dr_d          = 1'b0;
        or_d          = 1'b0;
        case (blk_state)
            ST_IDLE: begin
                skp_cnt_d     = '0;
                skp_pending_d = 1'b0;
            end
            ST_G12: begin
                tx_valid_d = 1'b1;
                if (os_valid) begin
                    or_d      = 1'b1;
                    off_d     = 1'b1;
                    tx_data_d = os_data;
                end else if (data_valid) begin
                    dr_d      = 1'b1;
                    tx_data_d = data_in;
                end
            end
            default: begin
                tx_valid_d = 1'b1;
                bs_d       = at_bound;
                if (at_bound) sh_d = (blk_state == ST_BLK_DATA) ? SH_DATA : SH_OS;
                beat_cnt_d = last_beat ? 4'd0 : beat_cnt_q + 4'd1;
                case (blk_state)
                    ST_BLK_DATA: begin
                        dr_d      = 1'b1;
                        tx_data_d = data_valid ? data_in : '0;
                    end
                    ST_BLK_OS: begin
                        or_d      = 1'b1;
                        tx_data_d = os_valid ? os_data : '0;
                    end
                    default: begin
                        tx_data_d  = skp_word;
                        skp_sent_d = at_bound;
                        if (at_bound) skp_pending_d = 1'b0;
                    end
                endcase
                // SKP blocks themselves do not count toward the interval.
                if (last_beat && blk_state != ST_BLK_SKP) begin
                    if (skp_cnt_q == CNT_W'(SKP_INTERVAL - 1)) begin
                        skp_pending_d = 1'b1;
                        skp_cnt_d     = '0;
                    end else begin
                        skp_cnt_d = skp_cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            beat_cnt_q    <= 4'd0;
            bpb_q         <= 5'd4;
            pw_q          <= 6'd32;
            skp_cnt_q     <= '0;
            skp_pending_q <= 1'b0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            sh_q          <= SH_NONE;
            bs_q          <= 1'b0;
            off_q         <= 1'b0;
            skp_sent_q    <= 1'b0;
            dr_q          <= 1'b0;
            or_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            bpb_q         <= bpb_d;
            pw_q          <= pw_d;
            skp_cnt_q     <= skp_cnt_d;
            skp_pending_q <= skp_pending_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            sh_q          <= sh_d;
            bs_q          <= bs_d;
            off_q         <= off_d;
            skp_sent_q    <= skp_sent_d;
            dr_q          <= dr_d;
            or_q          <= or_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign syncHeader  = sh_q;
    assign block_start = bs_q;
    assign turnOff     = off_q;
    assign skp_sent    = skp_sent_q;
    assign data_ready  = dr_q;
    assign os_ready    = or_q;

endmodule

// File: tb/tb_tx_block_scheduler.sv
// Bench for tx_block_scheduler: vector table, directed block sequences and a
// randomized run against a block-level reference model.
module tb_tx_block_scheduler;

    localparam int SKP_INT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  PIPEWIDTH = 6'd32;
    logic [2:0]  GEN = 3'd3;
    logic        link_up = 1'b0;
    logic        data_valid = 1'b0;
    logic [31:0] data_in = '0;
    logic        data_ready;
    logic        os_valid = 1'b0;
    logic [31:0] os_data = '0;
    logic        os_ready;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic [1:0]  syncHeader;
    logic        block_start;
    logic        turnOff;
    logic        skp_sent;

    always #5 clk = ~clk;

    tx_block_scheduler #(.SKP_INTERVAL(SKP_INT), .CNT_W(9)) dut (
        .clk(clk), .reset(reset), .PIPEWIDTH(PIPEWIDTH), .GEN(GEN), .link_up(link_up),
        .data_valid(data_valid), .data_in(data_in), .data_ready(data_ready),
        .os_valid(os_valid), .os_data(os_data), .os_ready(os_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .syncHeader(syncHeader),
        .block_start(block_start), .turnOff(turnOff), .skp_sent(skp_sent)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] outs();
        return {tx_data, tx_valid, syncHeader, block_start, turnOff, skp_sent, data_ready, os_ready};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        link_up = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    // Reference model: tracks the block in flight as "beats remaining" and
    // counts whole non-SKP blocks toward the next owed SKP.
    int m_kind = 0;      // 0 idle, 1 gen1/2, 2 data, 3 os, 4 skp
    int m_left = 0;
    int m_bpb  = 4;
    int m_pw   = 32;
    int m_blocks = 0;
    bit m_owe = 1'b0;

    task automatic model_step(output logic [39:0] e);
        logic [31:0] d;
        logic [1:0]  sh;
        logic        v, bs, off, sk, dr, orr;
        int          beat, spb, n;
        d = '0; sh = 2'b00; v = 0; bs = 0; off = 0; sk = 0; dr = 0; orr = 0;
        if (reset) begin
            m_kind = 0; m_left = 0; m_blocks = 0; m_owe = 0;
        end else begin
            if (m_left == 0) begin
                if (!link_up)         m_kind = 0;
                else if (GEN < 3'd3)  m_kind = 1;
                else if (m_owe)       m_kind = 4;
                else if (os_valid)    m_kind = 3;
                else                  m_kind = 2;
                if (m_kind >= 2) begin
                    m_pw   = (PIPEWIDTH == 6'd8 || PIPEWIDTH == 6'd16) ? int'(PIPEWIDTH) : 32;
                    m_bpb  = 128 / m_pw;
                    m_left = m_bpb;
                end
            end
            if (m_kind == 0) begin
                m_blocks = 0; m_owe = 0;
            end else if (m_kind == 1) begin
                v = 1;
                if (os_valid) begin d = os_data; orr = 1; off = 1; end
                else if (data_valid) begin d = data_in; dr = 1; end
            end else begin
                beat = m_bpb - m_left;
                v = 1;
                if (beat == 0) begin bs = 1; sh = (m_kind == 2) ? 2'b01 : 2'b10; end
                if (m_kind == 2) begin
                    dr = 1; d = data_valid ? data_in : 32'h0;
                end else if (m_kind == 3) begin
                    orr = 1; d = os_valid ? os_data : 32'h0;
                end else begin
                    spb = m_pw / 8;
                    if (beat == 0) begin sk = 1; m_owe = 0; end
                    for (int l = 0; l < spb; l++) begin
                        n = beat * spb + l;
                        d[8*l +: 8] = (n < 12) ? 8'hAA : (n == 12) ? 8'hE1 : 8'h00;
                    end
                end
                m_left--;
                if (m_left == 0 && m_kind != 4) begin
                    m_blocks++;
                    if (m_blocks == SKP_INT) begin m_owe = 1; m_blocks = 0; end
                end
            end
        end
        e = {d, v, sh, bs, off, sk, dr, orr};
    endtask

    typedef struct {
        int rst, lnk, gen, pw, dv, din, ov, od;
        int e_data, e_vld, e_sh, e_bs, e_off, e_skp, e_dr, e_or;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [39:0] e;
        logic [31:0] od;
        logic [7:0]  sb;
        int          pulses;

        // rst lnk gen pw dv din ov od | data vld sh bs off skp dr or
        tbl[0]  = '{1, 0, 2, 32, 0, 0,            0, 0,            0,            0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 2, 32, 1, 32'hAABBCCDD, 1, 32'h11223344, 32'h11223344, 1, 0, 0, 1, 0, 0, 1};
        tbl[2]  = '{0, 1, 2, 32, 1, 32'h55667788, 0, 0,            32'h55667788, 1, 0, 0, 0, 0, 1, 0};
        tbl[3]  = '{0, 1, 2, 32, 0, 0,            0, 0,            0,            1, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 2, 32, 1, 32'h1234,     1, 32'h5678,     0,            0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 3, 32, 1, 32'hCAFEF00D, 0, 0,            32'hCAFEF00D, 1, 1, 1, 0, 0, 1, 0};
        tbl[6]  = '{0, 1, 2, 32, 1, 1,            0, 0,            1,            1, 0, 0, 0, 0, 1, 0};
        tbl[7]  = '{0, 1, 2, 32, 0, 0,            0, 0,            0,            1, 0, 0, 0, 0, 1, 0};
        tbl[8]  = '{0, 1, 2, 32, 0, 0,            1, 2,            0,            1, 0, 0, 0, 0, 1, 0};
        tbl[9]  = '{0, 1, 2, 32, 0, 0,            1, 2,            2,            1, 0, 0, 1, 0, 0, 1};
        tbl[10] = '{0, 1, 3, 8,  0, 0,            1, 3,            3,            1, 2, 1, 0, 0, 0, 1};
        tbl[11] = '{0, 1, 3, 8,  1, 9,            0, 0,            0,            1, 0, 0, 0, 0, 0, 1};

        for (int r = 0; r < 12; r++) begin
            reset = 1'(tbl[r].rst); link_up = 1'(tbl[r].lnk); GEN = 3'(tbl[r].gen);
            PIPEWIDTH = 6'(tbl[r].pw); data_valid = 1'(tbl[r].dv); data_in = 32'(tbl[r].din);
            os_valid = 1'(tbl[r].ov); os_data = 32'(tbl[r].od);
            cyc();
            chk($sformatf("tbl[%0d]", r), 64'(outs()),
                64'({32'(tbl[r].e_data), 1'(tbl[r].e_vld), 2'(tbl[r].e_sh), 1'(tbl[r].e_bs),
                     1'(tbl[r].e_off), 1'(tbl[r].e_skp), 1'(tbl[r].e_dr), 1'(tbl[r].e_or)}));
        end

        // Gen3 framing at 32 bits per beat.
        do_reset();
        link_up = 1; GEN = 3; PIPEWIDTH = 32; data_valid = 1; os_valid = 0;
        for (int i = 0; i < 12; i++) begin
            data_in = 32'h100 + 32'(i);
            cyc();
            chk("frame_sh", 64'(syncHeader), (i % 4 == 0) ? 64'd1 : 64'd0);
            chk("frame_bs", 64'(block_start), 64'(i % 4 == 0));
            chk("frame_dr", 64'(data_ready), 64'd1);
            chk("frame_data", 64'(tx_data), 64'(32'h100 + 32'(i)));
        end

        // SKP scheduling at 8 bits per beat: four data blocks then one SKP block.
        do_reset();
        link_up = 1; GEN = 3; PIPEWIDTH = 8; data_valid = 1; os_valid = 0;
        for (int i = 0; i < 64; i++) begin
            data_in = 32'(i);
            cyc();
            chk("skp_pre_dr", 64'(data_ready), 64'd1);
            chk("skp_pre_sent", 64'(skp_sent), 64'd0);
            chk("skp_pre_sh", 64'(syncHeader), (i % 16 == 0) ? 64'd1 : 64'd0);
        end
        pulses = 0;
        for (int b = 0; b < 16; b++) begin
            cyc();
            sb = (b < 12) ? 8'hAA : (b == 12) ? 8'hE1 : 8'h00;
            chk("skp_data", 64'(tx_data), 64'(sb));
            chk("skp_dr", 64'(data_ready), 64'd0);
            chk("skp_sh", 64'(syncHeader), (b == 0) ? 64'd2 : 64'd0);
            if (skp_sent) pulses++;
        end
        chk("skp_pulses", 64'(pulses), 64'd1);
        cyc();
        chk("skp_after_sh", 64'(syncHeader), 64'd1);

        // OS request rising on beat 2 of a 16-bit data block.
        do_reset();
        link_up = 1; GEN = 3; PIPEWIDTH = 16; data_valid = 1; os_valid = 0;
        cyc(); cyc();
        os_valid = 1;
        for (int b = 2; b < 8; b++) begin
            os_data = $urandom;
            cyc();
            chk("osmid_dr", 64'(data_ready), 64'd1);
            chk("osmid_or", 64'(os_ready), 64'd0);
        end
        for (int b = 0; b < 8; b++) begin
            od = $urandom;
            os_data = od;
            cyc();
            chk("os_sh", 64'(syncHeader), (b == 0) ? 64'd2 : 64'd0);
            chk("os_or", 64'(os_ready), 64'd1);
            chk("os_dr", 64'(data_ready), 64'd0);
            chk("os_data", 64'(tx_data), 64'(od));
        end

        // SKP owed and OS requested at the same boundary: SKP goes first.
        do_reset();
        link_up = 1; GEN = 3; PIPEWIDTH = 32; data_valid = 1; os_valid = 0;
        for (int i = 0; i < 15; i++) cyc();
        os_valid = 1; os_data = 32'h0505_0505;
        cyc();
        chk("coll_last_data_or", 64'(os_ready), 64'd0);
        for (int b = 0; b < 4; b++) begin
            cyc();
            chk("coll_skp_data", 64'(tx_data), (b == 3) ? 64'h0000_00E1 : 64'hAAAA_AAAA);
            chk("coll_skp_or", 64'(os_ready), 64'd0);
            chk("coll_skp_sent", 64'(skp_sent), 64'(b == 0));
        end
        cyc();
        chk("coll_os_sh", 64'(syncHeader), 64'd2);
        chk("coll_os_or", 64'(os_ready), 64'd1);
        chk("coll_os_data", 64'(tx_data), 64'h0505_0505);

        // Reset on beat 5 of a 16-beat block.
        do_reset();
        link_up = 1; GEN = 3; PIPEWIDTH = 8; data_valid = 1; os_valid = 0; data_in = 32'h77;
        for (int i = 0; i < 5; i++) cyc();
        reset = 1;
        cyc();
        chk("rst_mid_outs", 64'(outs()), 64'd0);
        reset = 0;
        cyc();
        chk("rst_release_bs", 64'(block_start), 64'd1);
        chk("rst_release_sh", 64'(syncHeader), 64'd1);

        // Randomized run against the reference model.
        GEN = 3; PIPEWIDTH = 32;
        for (int i = 0; i < 3000; i++) begin
            reset   = (i == 0) || ($urandom_range(0, 299) == 0);
            link_up = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 39) == 0) GEN = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       PIPEWIDTH = 6'd8;
                    1:       PIPEWIDTH = 6'd16;
                    2:       PIPEWIDTH = 6'd32;
                    default: PIPEWIDTH = 6'($urandom_range(0, 63));
                endcase
            end
            data_valid = ($urandom_range(0, 3) != 0);
            data_in    = $urandom;
            os_valid   = ($urandom_range(0, 4) == 0);
            os_data    = $urandom;
            model_step(e);
            cyc();
            chk($sformatf("rand[%0d]", i), 64'(outs()), 64'(e));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
